xiphy_dly_update_seq: RTL and testbench



---
 rtl/xiphy_dly_pkg.sv | 27 ++
 rtl/xiphy_dly_lane_demux.sv | 44 ++++
 rtl/xiphy_dly_update_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_xiphy_dly_update_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xiphy_dly_pkg.sv
// Shared op/state types and tap helpers for the XiPHY delay-update sequencer.
// Optional shadow tap tracking in the top is enabled by XIPHY_DLY_SHADOW_EN.
package xiphy_dly_pkg;

    typedef enum logic [1:0] {
        DLY_INC  = 2'd0,
        DLY_DEC  = 2'd1,
        DLY_LOAD = 2'd2,
        DLY_READ = 2'd3
    } dly_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VTC_OFF,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_LOAD,
        ST_READBACK,
        ST_VTC_ON,
        ST_RESP
    } dly_state_e;

    function automatic logic [31:0] max_tap(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/xiphy_dly_lane_demux.sv
// Fans the sequencer's single-lane controls out to the selected bitslice
// and muxes that lane's CNTVALUEOUT back; unselected lanes stay idle.
module xiphy_dly_lane_demux
    import xiphy_dly_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int CNT_WIDTH = 9,
    parameter int LANE_W    = 3
) (
    input  logic [LANE_W-1:0]              lane,
    input  logic                           ce,
    input  logic                           inc,
    input  logic                           ld,
    input  logic                           vtc_off,
    input  logic [CNT_WIDTH-1:0]           cntvaluein,
    output logic [CNT_WIDTH-1:0]           cntvalueout,
    output logic [NUM_LANES-1:0]           dly_ce,
    output logic [NUM_LANES-1:0]           dly_inc,
    output logic [NUM_LANES-1:0]           dly_ld,
    output logic [NUM_LANES*CNT_WIDTH-1:0] dly_cntvaluein,
    output logic [NUM_LANES-1:0]           dly_en_vtc,
    input  logic [NUM_LANES*CNT_WIDTH-1:0] dly_cntvalueout
);

    always_comb begin
        dly_ce         = '0;
        dly_inc        = '0;
        dly_ld         = '0;
        dly_cntvaluein = '0;
        dly_en_vtc     = '1;
        cntvalueout    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) == lane) begin
                dly_ce[i]     = ce;
                dly_inc[i]    = inc;
                dly_ld[i]     = ld;
                dly_en_vtc[i] = ~vtc_off;
                dly_cntvaluein[i*CNT_WIDTH +: CNT_WIDTH] = cntvaluein;
                cntvalueout = dly_cntvalueout[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/xiphy_dly_update_seq.sv
// VTC-safe delay-update sequencer for XiPHY bitslice IDELAY/ODELAY lines.
// Define XIPHY_DLY_SHADOW_EN for per-lane shadow taps and rsp_mismatch.
module xiphy_dly_update_seq
    import xiphy_dly_pkg::*;
#(
    parameter int NUM_LANES      = 8,
    parameter int CNT_WIDTH      = 9,
    parameter int STEP_WIDTH     = 6,
    parameter int VTC_SETTLE_CYC = 8,
    parameter int READ_LAT       = 2,
    parameter int LANE_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [LANE_W-1:0]              req_lane,
    input  logic [1:0]                     req_op,
    input  logic [STEP_WIDTH-1:0]          req_steps,
    input  logic [CNT_WIDTH-1:0]           req_value,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [CNT_WIDTH-1:0]           rsp_value,
    output logic                           rsp_clamped,
    output logic                           rsp_err,
`ifdef XIPHY_DLY_SHADOW_EN
    output logic                           rsp_mismatch,
`endif
    output logic [NUM_LANES-1:0]           dly_ce,
    output logic [NUM_LANES-1:0]           dly_inc,
    output logic [NUM_LANES-1:0]           dly_ld,
    output logic [NUM_LANES*CNT_WIDTH-1:0] dly_cntvaluein,
    output logic [NUM_LANES-1:0]           dly_en_vtc,
    input  logic [NUM_LANES*CNT_WIDTH-1:0] dly_cntvalueout
);

    localparam logic [CNT_WIDTH-1:0] TAP_MAX = CNT_WIDTH'(max_tap(CNT_WIDTH));
    localparam int CMAX = (VTC_SETTLE_CYC > READ_LAT) ? VTC_SETTLE_CYC : READ_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    dly_state_e            state_q, state_d;
    dly_op_e               op_q, op_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [STEP_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_WIDTH-1:0]  value_q, value_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  rsp_value_q, rsp_value_d;
    logic                  clamped_q, clamped_d;
    logic                  err_q, err_d;
    logic                  live_q;

    logic                  ce, inc, ld, vtc_off, at_limit;
    logic [CNT_WIDTH-1:0]  cntvaluein, cur_tap;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        rem_d       = rem_q;
        value_d     = value_q;
        cnt_d       = cnt_q;
        rsp_value_d = rsp_value_q;
        clamped_d   = clamped_q;
        err_d       = err_q;
        ce          = 1'b0;
        inc         = 1'b0;
        ld          = 1'b0;
        vtc_off     = 1'b0;
        cntvaluein  = '0;
        at_limit    = (op_q == DLY_INC) ? (cur_tap == TAP_MAX) : (cur_tap == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && live_q) begin
                    lane_d      = req_lane;
                    op_d        = dly_op_e'(req_op);
                    rem_d       = req_steps;
                    value_d     = req_value;
                    rsp_value_d = '0;
                    clamped_d   = 1'b0;
                    cnt_d       = CW'(VTC_SETTLE_CYC - 1);
                    err_d       = (32'(req_lane) >= NUM_LANES);
                    state_d     = err_d ? ST_RESP : ST_VTC_OFF;
                end
            end
            ST_VTC_OFF: begin
                vtc_off = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == DLY_LOAD) begin
                    cnt_d   = CW'(1);
                    state_d = ST_LOAD;
                end else if (op_q == DLY_READ || rem_q == '0) begin
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = ST_READBACK;
                end else begin
                    state_d = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                vtc_off = 1'b1;
                // Limit is checked on the live tap so we never wrap the line.
                if (at_limit) begin
                    clamped_d = 1'b1;
                    cnt_d     = CW'(READ_LAT - 1);
                    state_d   = ST_READBACK;
                end else begin
                    ce      = 1'b1;
                    inc     = (op_q == DLY_INC);
                    rem_d   = rem_q - 1'b1;
                    state_d = ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                vtc_off = 1'b1;
                if (rem_q != '0) begin
                    state_d = ST_STEP_HI;
                end else begin
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = ST_READBACK;
                end
            end
            ST_LOAD: begin
                vtc_off    = 1'b1;
                cntvaluein = value_q;
                ld         = (cnt_q != '0);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = ST_READBACK;
                end
            end
            ST_READBACK: begin
                vtc_off = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_value_d = cur_tap;
                    state_d     = ST_VTC_ON;
                end
            end
            ST_VTC_ON: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= DLY_INC;
            lane_q      <= '0;
            rem_q       <= '0;
            value_q     <= '0;
            cnt_q       <= '0;
            rsp_value_q <= '0;
            clamped_q   <= 1'b0;
            err_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            rem_q       <= rem_d;
            value_q     <= value_d;
            cnt_q       <= cnt_d;
            rsp_value_q <= rsp_value_d;
            clamped_q   <= clamped_d;
            err_q       <= err_d;
            live_q      <= 1'b1;
        end
    end

    assign req_ready   = live_q && (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_value   = rsp_value_q;
    assign rsp_clamped = clamped_q;
    assign rsp_err     = err_q;

    xiphy_dly_lane_demux #(
        .NUM_LANES (NUM_LANES),
        .CNT_WIDTH (CNT_WIDTH),
        .LANE_W    (LANE_W)
    ) u_demux (
        .lane            (lane_q),
        .ce              (ce),
        .inc             (inc),
        .ld              (ld),
        .vtc_off         (vtc_off),
        .cntvaluein      (cntvaluein),
        .cntvalueout     (cur_tap),
        .dly_ce          (dly_ce),
        .dly_inc         (dly_inc),
        .dly_ld          (dly_ld),
        .dly_cntvaluein  (dly_cntvaluein),
        .dly_en_vtc      (dly_en_vtc),
        .dly_cntvalueout (dly_cntvalueout)
    );

`ifdef XIPHY_DLY_SHADOW_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_LANES];
    logic [CNT_WIDTH-1:0] shadow_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (LANE_W'(i) == lane_q) begin
                    if (ce)
                        shadow_q[i] <= inc ? shadow_q[i] + 1'b1 : shadow_q[i] - 1'b1;
                    else if (ld)
                        shadow_q[i] <= value_q;
                    else if (state_q == ST_RESP && rsp_ready && !err_q)
                        shadow_q[i] <= rsp_value_q;
                end
            end
        end
    end

    always_comb begin
        shadow_sel = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (LANE_W'(i) == lane_q) shadow_sel = shadow_q[i];
    end

    assign rsp_mismatch = (state_q == ST_RESP) && !err_q && (shadow_sel != rsp_value_q);
`endif

endmodule

// File: tb/tb_xiphy_dly_update_seq.sv
// Directed bench for xiphy_dly_update_seq with a behavioural delay-line model.
// Shadow checks are compiled in when XIPHY_DLY_SHADOW_EN is defined.
module tb_xiphy_dly_update_seq;

    // Six lanes so that a 3-bit req_lane can address an out-of-range lane.
    localparam int NL = 6;
    localparam int CW = 9;
    localparam int SW = 6;
    localparam int LW = 3;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [LW-1:0]     req_lane;
    logic [1:0]        req_op;
    logic [SW-1:0]     req_steps;
    logic [CW-1:0]     req_value;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CW-1:0]     rsp_value;
    logic              rsp_clamped;
    logic              rsp_err;
    logic              rsp_mismatch;
    logic [NL-1:0]     dly_ce, dly_inc, dly_ld, dly_en_vtc;
    logic [NL*CW-1:0]  dly_cntvaluein;
    logic [NL*CW-1:0]  dly_cntvalueout;

    int n_checks = 0;
    int n_fail   = 0;

    xiphy_dly_update_seq #(
        .NUM_LANES (NL),
        .CNT_WIDTH (CW),
        .STEP_WIDTH(SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_lane        (req_lane),
        .req_op          (req_op),
        .req_steps       (req_steps),
        .req_value       (req_value),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_value       (rsp_value),
        .rsp_clamped     (rsp_clamped),
        .rsp_err         (rsp_err),
`ifdef XIPHY_DLY_SHADOW_EN
        .rsp_mismatch    (rsp_mismatch),
`endif
        .dly_ce          (dly_ce),
        .dly_inc         (dly_inc),
        .dly_ld          (dly_ld),
        .dly_cntvaluein  (dly_cntvaluein),
        .dly_en_vtc      (dly_en_vtc),
        .dly_cntvalueout (dly_cntvalueout)
    );

`ifndef XIPHY_DLY_SHADOW_EN
    assign rsp_mismatch = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-line model: zero-latency CNTVALUEOUT, LOAD wins over CE.
    logic          set_en = 1'b0;
    int            set_lane = 0;
    logic [CW-1:0] set_val = '0;
    logic [CW-1:0] tap [NL];

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!rst_n)
                tap[i] <= '0;
            else if (set_en && set_lane == i)
                tap[i] <= set_val;
            else if (dly_ld[i])
                tap[i] <= dly_cntvaluein[i*CW +: CW];
            else if (dly_ce[i])
                tap[i] <= dly_inc[i] ? tap[i] + 1'b1 : tap[i] - 1'b1;
        end
    end

    always_comb begin
        dly_cntvalueout = '0;
        for (int i = 0; i < NL; i++) dly_cntvalueout[i*CW +: CW] = tap[i];
    end

    // Per-request activity monitor, sampled on the falling edge.
    logic mon_clr = 1'b0;
    int   mon_lane = 0;
    int   n_ce = 0, n_ld = 0, n_cv = 0, pre_low = 0, b2b = 0, other = 0;
    int   cv_ld = 0;
    logic prev_ce = 1'b0, rsp_seen = 1'b0, vtc_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_ce <= 0; n_ld <= 0; n_cv <= 0; pre_low <= 0; b2b <= 0;
            other <= 0; cv_ld <= 0; prev_ce <= 1'b0;
            rsp_seen <= 1'b0; vtc_prev <= 1'b0;
        end else begin
            if (mon_lane < NL) begin
                if (dly_ce[mon_lane]) begin
                    n_ce <= n_ce + 1;
                    if (prev_ce) b2b <= b2b + 1;
                end
                if (dly_ld[mon_lane]) begin
                    n_ld  <= n_ld + 1;
                    cv_ld <= int'(dly_cntvaluein[mon_lane*CW +: CW]);
                end
                if (dly_cntvaluein[mon_lane*CW +: CW] != '0) n_cv <= n_cv + 1;
                if (!dly_en_vtc[mon_lane] && !dly_ce[mon_lane] && !dly_ld[mon_lane]
                    && n_ce == 0 && n_ld == 0)
                    pre_low <= pre_low + 1;
                prev_ce <= dly_ce[mon_lane];
                if (rsp_valid) rsp_seen <= 1'b1;
                else if (!rsp_seen) vtc_prev <= dly_en_vtc[mon_lane];
            end
            for (int i = 0; i < NL; i++)
                if (i != mon_lane && (dly_ce[i] || dly_ld[i] || !dly_en_vtc[i]
                    || dly_cntvaluein[i*CW +: CW] != '0))
                    other <= other + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preset(input int lane, input int v);
        set_lane = lane;
        set_val  = CW'(v);
        set_en   = 1'b1;
        @(posedge clk); #1;
        set_en   = 1'b0;
    endtask

    logic          got_rdy, timed_out, got_clamp, got_err, got_mm;
    logic [CW-1:0] got_value;
    int            unstable, rdy_hi;

    task automatic do_req(input int lane, input int op, input int steps,
                          input int val, input int hold);
        int n;
        mon_lane = lane;
        mon_clr  = 1'b1;
        @(posedge clk); #1;
        mon_clr   = 1'b0;
        req_lane  = LW'(lane);
        req_op    = 2'(op);
        req_steps = SW'(steps);
        req_value = CW'(val);
        req_valid = 1'b1;
        got_rdy   = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        timed_out = !rsp_valid;
        got_value = rsp_value;
        got_clamp = rsp_clamped;
        got_err   = rsp_err;
        got_mm    = rsp_mismatch;
        unstable  = 0;
        rdy_hi    = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_value != got_value || rsp_clamped != got_clamp
                || rsp_err != got_err)
                unstable++;
            if (req_ready) rdy_hi++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_lane  = '0;
        req_op    = '0;
        req_steps = '0;
        req_value = '0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_value", rsp_value, 0);
        check("rst_en_vtc", dly_en_vtc, 6'h3f);
        check("rst_ce_ld", {dly_ce, dly_ld}, 0);
        check("rst_cntvaluein", dly_cntvaluein, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", req_ready, 1);

        // INC lane 3 by 5 from tap 10
        preset(3, 10);
        do_req(3, 0, 5, 0, 0);
        check("inc_timeout", timed_out, 0);
        check("inc_accept_rdy", got_rdy, 1);
        check("inc_value", got_value, 15);
        check("inc_clamped", got_clamp, 0);
        check("inc_err", got_err, 0);
        check("inc_pulses", n_ce, 5);
        check("inc_settle", pre_low, 8);
        check("inc_gap", b2b, 0);
        check("inc_other", other, 0);
        check("inc_vtc_on", vtc_prev, 1);

        // DEC lane 0 by 4 from tap 2: clamps at zero
        preset(0, 2);
        do_req(0, 1, 4, 0, 0);
        check("dec_timeout", timed_out, 0);
        check("dec_value", got_value, 0);
        check("dec_clamped", got_clamp, 1);
        check("dec_pulses", n_ce, 2);
        check("dec_other", other, 0);

        // LOAD lane 5 with 0x1A5
        do_req(5, 2, 0, 'h1A5, 0);
        check("ld_timeout", timed_out, 0);
        check("ld_value", got_value, 'h1A5);
        check("ld_pulses", n_ld, 1);
        check("ld_cv", cv_ld, 'h1A5);
        check("ld_cv_cycles", n_cv, 2);
        check("ld_ce", n_ce, 0);
        check("ld_settle", pre_low, 8);
        check("ld_vtc_on", vtc_prev, 1);
        check("ld_other", other, 0);

        // Out-of-range lane
        do_req(7, 0, 3, 0, 0);
        check("err_timeout", timed_out, 0);
        check("err_flag", got_err, 1);
        check("err_value", got_value, 0);
        check("err_activity", other, 0);

        // steps=0 INC: readback only, response held 10 cycles
        preset(2, 100);
        do_req(2, 0, 0, 0, 10);
        check("zero_value", got_value, 100);
        check("zero_pulses", n_ce, 0);
        check("zero_clamped", got_clamp, 0);
        check("hold_stable", unstable, 0);
        check("hold_ready_low", rdy_hi, 0);

        // READ lane 1
        preset(1, 77);
        do_req(1, 3, 9, 0, 0);
        check("read_value", got_value, 77);
        check("read_activity", n_ce + n_ld, 0);

        // INC lane 4 from 510 by 3: one pulse, then clamp at max
        preset(4, 510);
        do_req(4, 0, 3, 0, 0);
        check("max_value", got_value, 511);
        check("max_clamped", got_clamp, 1);
        check("max_pulses", n_ce, 1);

`ifdef XIPHY_DLY_SHADOW_EN
        // Lane 3 shadow resynced to 15; corrupt the line by +1 first.
        preset(3, 16);
        do_req(3, 0, 2, 0, 0);
        check("shadow_value", got_value, 18);
        check("shadow_mismatch", got_mm, 1);
        do_req(3, 0, 2, 0, 0);
        check("shadow_value2", got_value, 20);
        check("shadow_match", got_mm, 0);
`endif

        // Reset while a step pulse is active
        preset(1, 20);
        req_lane  = LW'(1);
        req_op    = 2'd0;
        req_steps = SW'(5);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!dly_ce[1] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_reach_step", dly_ce[1], 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_en_vtc", dly_en_vtc, 6'h3f);
        check("rst_mid_ce", dly_ce, 0);
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_release", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
